// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock: FSM state encoding,
// BCD digit limits and digit widths.
package clock_pkg;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    localparam int HOUR_TENS_W = 2;
    localparam int DIGIT_W     = 4;

    localparam logic [3:0] SEC_TENS_MAX        = 4'd5;
    localparam logic [3:0] UNITS_MAX           = 4'd9;
    localparam logic [1:0] HOUR_MAX_TENS       = 2'd2;
    localparam logic [3:0] HOUR_MAX_UNITS_AT_2 = 4'd3;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with synchronous load and wrap at MAX; carry_out is the
// combinational increment request for the next more significant digit.
module bcd_digit_counter #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = W'(9)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         carry_out
);

    assign carry_out = inc && (q == MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            q <= (q == MAX) ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter: tracks set digits while set_mode is high, then counts
// seconds from a prescaled 1 Hz tick and flags the midnight rollover.
module time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int PRE_W  = 26
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_mode,
    input  logic [HOUR_TENS_W-1:0] set_h1,
    input  logic [DIGIT_W-1:0]     set_h2,
    input  logic [DIGIT_W-1:0]     set_m1,
    input  logic [DIGIT_W-1:0]     set_m2,
    input  logic [DIGIT_W-1:0]     set_s1,
    input  logic [DIGIT_W-1:0]     set_s2,
    output logic [HOUR_TENS_W-1:0] hour1,
    output logic [DIGIT_W-1:0]     hour2,
    output logic [DIGIT_W-1:0]     min1,
    output logic [DIGIT_W-1:0]     min2,
    output logic [DIGIT_W-1:0]     sec1,
    output logic [DIGIT_W-1:0]     sec2,
    output logic                   tick_1hz,
    output logic                   midnight
);

    state_t           state, state_next;
    logic             set_mode_q;
    logic             load;
    logic [PRE_W-1:0] prescaler;
    logic             pre_wrap, tick, at_midnight;
    logic             s2_carry, s1_carry, m2_carry, m1_carry;
    logic [7:0]       sec_load, min_load;
    logic [5:0]       hour_load;

    // An out-of-range field collapses to zero rather than loading garbage.
    function automatic logic [7:0] sanitise_ms(input logic [3:0] tens, input logic [3:0] units);
        if (tens > SEC_TENS_MAX || units > UNITS_MAX)
            return 8'h00;
        return {tens, units};
    endfunction

    function automatic logic [5:0] sanitise_hours(input logic [1:0] tens, input logic [3:0] units);
        if (tens > HOUR_MAX_TENS || units > UNITS_MAX ||
            (tens == HOUR_MAX_TENS && units > HOUR_MAX_UNITS_AT_2))
            return 6'h00;
        return {tens, units};
    endfunction

    assign sec_load  = sanitise_ms(set_s1, set_s2);
    assign min_load  = sanitise_ms(set_m1, set_m2);
    assign hour_load = sanitise_hours(set_h1, set_h2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            set_mode_q <= 1'b0;
        end else begin
            state      <= state_next;
            set_mode_q <= set_mode;
        end
    end

    // SET keeps loading through the cycle where set_mode falls, committing the final value.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            RUN: begin
                load = set_mode;
                if (set_mode) state_next = SET;
            end
            SET: begin
                load = 1'b1;
                if (!set_mode && set_mode_q) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    assign pre_wrap = (prescaler == PRE_W'(CLK_HZ - 1));
    assign tick     = pre_wrap && !load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (load || pre_wrap) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    bcd_digit_counter #(.W(DIGIT_W), .MAX(UNITS_MAX)) u_s2 (
        .clk(clk), .reset(reset), .inc(tick), .load(load),
        .load_val(sec_load[3:0]), .q(sec2), .carry_out(s2_carry)
    );
    bcd_digit_counter #(.W(DIGIT_W), .MAX(SEC_TENS_MAX)) u_s1 (
        .clk(clk), .reset(reset), .inc(s2_carry), .load(load),
        .load_val(sec_load[7:4]), .q(sec1), .carry_out(s1_carry)
    );
    bcd_digit_counter #(.W(DIGIT_W), .MAX(UNITS_MAX)) u_m2 (
        .clk(clk), .reset(reset), .inc(s1_carry), .load(load),
        .load_val(min_load[3:0]), .q(min2), .carry_out(m2_carry)
    );
    bcd_digit_counter #(.W(DIGIT_W), .MAX(SEC_TENS_MAX)) u_m1 (
        .clk(clk), .reset(reset), .inc(m2_carry), .load(load),
        .load_val(min_load[7:4]), .q(min1), .carry_out(m1_carry)
    );

    // Hours are a joint two-digit counter because units wrap at 3 only when tens is 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour1 <= '0;
            hour2 <= '0;
        end else if (load) begin
            hour1 <= hour_load[5:4];
            hour2 <= hour_load[3:0];
        end else if (m1_carry) begin
            if (hour1 == HOUR_MAX_TENS && hour2 == HOUR_MAX_UNITS_AT_2) begin
                hour1 <= '0;
                hour2 <= '0;
            end else if (hour2 == UNITS_MAX) begin
                hour1 <= hour1 + 2'd1;
                hour2 <= '0;
            end else begin
                hour2 <= hour2 + 4'd1;
            end
        end
    end

    assign at_midnight = (hour1 == HOUR_MAX_TENS) && (hour2 == HOUR_MAX_UNITS_AT_2) &&
                         (min1 == SEC_TENS_MAX) && (min2 == UNITS_MAX) &&
                         (sec1 == SEC_TENS_MAX) && (sec2 == UNITS_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_1hz <= 1'b0;
            midnight <= 1'b0;
        end else begin
            tick_1hz <= tick;
            midnight <= tick && at_midnight;
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with a 4-cycle second: counting, loading,
// sanitising, carry chains, midnight pulse, reset and set/tick collision.
module tb_time_counter;

    localparam int CLK_HZ = 4;
    localparam int PRE_W  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set_mode = 1'b0;
    logic [1:0] set_h1 = '0;
    logic [3:0] set_h2 = '0, set_m1 = '0, set_m2 = '0, set_s1 = '0, set_s2 = '0;
    logic [1:0] hour1;
    logic [3:0] hour2, min1, min2, sec1, sec2;
    logic       tick_1hz, midnight;

    int checks = 0;
    int failures = 0;
    int ticks;

    time_counter #(.CLK_HZ(CLK_HZ), .PRE_W(PRE_W)) dut (
        .clk(clk), .reset(reset), .set_mode(set_mode),
        .set_h1(set_h1), .set_h2(set_h2), .set_m1(set_m1),
        .set_m2(set_m2), .set_s1(set_s1), .set_s2(set_s2),
        .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2),
        .sec1(sec1), .sec2(sec2), .tick_1hz(tick_1hz), .midnight(midnight)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] cur_time();
        return {2'b00, hour1, hour2, min1, min2, sec1, sec2};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds set_mode for two cycles, then drops it; afterwards the prescaler is 0.
    task automatic load_time(input logic [1:0] h1, input logic [3:0] h2, input logic [3:0] m1,
                             input logic [3:0] m2, input logic [3:0] s1, input logic [3:0] s2);
        set_h1 = h1; set_h2 = h2; set_m1 = m1; set_m2 = m2; set_s1 = s1; set_s2 = s2;
        set_mode = 1'b1;
        step(2);
        set_mode = 1'b0;
        step(1);
    endtask

    initial begin
        #1 reset = 1'b1;
        step(2);
        check_eq("reset_time", cur_time(), 24'h000000);
        check_eq("reset_tick", tick_1hz, 1'b0);
        check_eq("reset_midnight", midnight, 1'b0);
        reset = 1'b0;

        // free run from reset: ticks on cycles 4, 8, 12
        ticks = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (tick_1hz) begin
                ticks++;
                check_eq("tick_spacing", i % CLK_HZ, 0);
            end
        end
        check_eq("run_tick_count", ticks, 3);
        check_eq("run_time", cur_time(), 24'h000003);

        load_time(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        check_eq("load_123456", cur_time(), 24'h123456);
        step(3);
        check_eq("no_early_tick", tick_1hz, 1'b0);
        check_eq("hold_123456", cur_time(), 24'h123456);
        step(1);
        check_eq("first_tick", tick_1hz, 1'b1);
        check_eq("inc_123457", cur_time(), 24'h123457);

        load_time(2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
        check_eq("load_235959", cur_time(), 24'h235959);
        step(3);
        check_eq("pre_midnight", midnight, 1'b0);
        step(1);
        check_eq("wrap_000000", cur_time(), 24'h000000);
        check_eq("midnight_pulse", midnight, 1'b1);
        check_eq("midnight_tick", tick_1hz, 1'b1);
        step(1);
        check_eq("midnight_clear", midnight, 1'b0);
        check_eq("tick_clear", tick_1hz, 1'b0);

        load_time(2'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
        step(4);
        check_eq("carry_100000", cur_time(), 24'h100000);
        check_eq("no_midnight_10", midnight, 1'b0);
        load_time(2'd1, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
        step(4);
        check_eq("carry_200000", cur_time(), 24'h200000);
        load_time(2'd1, 4'd2, 4'd0, 4'd9, 4'd5, 4'd9);
        step(4);
        check_eq("carry_121000", cur_time(), 24'h121000);

        load_time(2'd2, 4'd5, 4'd6, 4'd7, 4'd5, 4'hA);
        check_eq("sanitise_all", cur_time(), 24'h000000);
        load_time(2'd2, 4'd4, 4'd3, 4'd0, 4'd3, 4'd0);
        check_eq("sanitise_hours", cur_time(), 24'h003030);

        // reset two cycles before a tick
        load_time(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        step(2);
        reset = 1'b1;
        #1;
        check_eq("async_reset_time", cur_time(), 24'h000000);
        check_eq("async_reset_tick", tick_1hz, 1'b0);
        step(1);
        reset = 1'b0;
        ticks = 0;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            if (tick_1hz) ticks++;
        end
        check_eq("no_tick_after_reset", ticks, 0);
        check_eq("zero_after_reset", cur_time(), 24'h000000);
        step(1);
        check_eq("tick_after_reset", tick_1hz, 1'b1);
        check_eq("time_after_reset", cur_time(), 24'h000001);

        // set_mode raised on the cycle the prescaler would wrap
        set_h1 = 2'd0; set_h2 = 4'd0; set_m1 = 4'd0; set_m2 = 4'd0; set_s1 = 4'd0; set_s2 = 4'd1;
        step(3);
        set_mode = 1'b1;
        step(1);
        check_eq("set_wins_tick", tick_1hz, 1'b0);
        check_eq("set_wins_time", cur_time(), 24'h000001);
        step(5);
        check_eq("set_frozen_tick", tick_1hz, 1'b0);
        check_eq("set_frozen_time", cur_time(), 24'h000001);
        set_mode = 1'b0;
        step(1);
        step(4);
        check_eq("resume_tick", tick_1hz, 1'b1);
        check_eq("resume_time", cur_time(), 24'h000002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
